// File: rtl/tl_mem_responder.sv
// TileLink-style memory responder: one 64-bit wide backing store that serves
// Put/Get/Acquire on A, Release/ReleaseData on C, and completes grants on E.
// Only one transaction is in flight at a time. C has priority over A.
module tl_mem_responder #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
   input  logic        clock,
   input  logic        reset,
   // A channel
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [2:0]  a_opcode,
   input  logic [2:0]  a_param,
   input  logic [2:0]  a_size,
   input  logic [2:0]  a_source,
   input  logic [31:0] a_address,
   input  logic [7:0]  a_mask,
   input  logic [63:0] a_data,
   // B channel
   output logic        b_valid,
   input  logic        b_ready,
   // C channel
   input  logic        c_valid,
   output logic        c_ready,
   input  logic [2:0]  c_opcode,
   input  logic [2:0]  c_param,
   input  logic [2:0]  c_size,
   input  logic [2:0]  c_source,
   input  logic [31:0] c_address,
   input  logic [63:0] c_data,
   // D channel
   output logic        d_valid,
   input  logic        d_ready,
   output logic [2:0]  d_opcode,
   output logic [1:0]  d_param,
   output logic [2:0]  d_size,
   output logic [2:0]  d_source,
   output logic [1:0]  d_sink,
   output logic [63:0] d_data,
   // E channel
   input  logic        e_valid,
   output logic        e_ready,
   input  logic [1:0]  e_sink
);

   localparam int unsigned AW = $clog2(MEM_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      A_PUT,
      C_REL,
      D_DATA,
      D_ACK,
      WAIT_E
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     beat_q, beat_d;
   logic [2:0]     last_q, last_d;
   logic [AW-1:0]  base_q, base_d;
   logic [2:0]     dop_q, dop_d;
   logic [1:0]     dparam_q, dparam_d;
   logic [2:0]     size_q, size_d;
   logic [2:0]     source_q, source_d;
   logic           grant_q, grant_d;
   logic           retw_q, retw_d;
   logic           wr_q, wr_d;
   logic [63:0]    ddata_q;

   logic [63:0]    mem_q [MEM_WORDS];

   logic           mem_we;
   logic [AW-1:0]  mem_idx;
   logic [63:0]    mem_wdata;
   logic [7:0]     mem_wmask;
   logic           rd_load;
   logic [AW-1:0]  rd_idx;

   logic           a_start;
   logic           c_start;
   logic [2:0]     nb;
   logic [31:0]    a_off;
   logic [31:0]    c_off;
   logic [AW-1:0]  a_base;
   logic [AW-1:0]  c_base;
   logic           unused_bits;

   // Index of the last beat of a burst for a given size (sizes above 6 clamp to 8 beats).
   function automatic logic [2:0] last_beat(input logic [2:0] sz);
      case (sz)
         3'd4:    last_beat = 3'd1;
         3'd5:    last_beat = 3'd3;
         3'd6,
         3'd7:    last_beat = 3'd7;
         default: last_beat = 3'd0;
      endcase
   endfunction

   assign nb     = beat_q + 3'd1;
   assign a_off  = a_address - BASE_ADDR;
   assign c_off  = c_address - BASE_ADDR;
   assign a_base = a_off[AW+2:3];
   assign c_base = c_off[AW+2:3];

   assign unused_bits = ^{b_ready, e_sink, c_param, a_off[2:0], a_off[31:AW+3],
                          c_off[2:0], c_off[31:AW+3]};

   assign b_valid  = 1'b0;
   assign d_opcode = dop_q;
   assign d_param  = dparam_q;
   assign d_size   = size_q;
   assign d_source = source_q;
   assign d_sink   = 2'd0;
   assign d_data   = ddata_q;

   // State register and latched request fields.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         last_q   <= '0;
         base_q   <= '0;
         dop_q    <= '0;
         dparam_q <= '0;
         size_q   <= '0;
         source_q <= '0;
         grant_q  <= 1'b0;
         retw_q   <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         last_q   <= last_d;
         base_q   <= base_d;
         dop_q    <= dop_d;
         dparam_q <= dparam_d;
         size_q   <= size_d;
         source_q <= source_d;
         grant_q  <= grant_d;
         retw_q   <= retw_d;
         wr_q     <= wr_d;
      end
   end

   // Backing store write port with per-byte enables; contents survive reset.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (mem_wmask[i]) mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   // Registered read data: loaded when a read burst starts and on each accepted data beat.
   always_ff @(posedge clock) begin
      if (reset)        ddata_q <= '0;
      else if (rd_load) ddata_q <= mem_q[rd_idx];
   end

   // Next-state, channel readies, memory strobes.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      last_d    = last_q;
      base_d    = base_q;
      dop_d     = dop_q;
      dparam_d  = dparam_q;
      size_d    = size_q;
      source_d  = source_q;
      grant_d   = grant_q;
      retw_d    = retw_q;
      wr_d      = wr_q;
      a_ready   = 1'b0;
      c_ready   = 1'b0;
      e_ready   = 1'b0;
      d_valid   = 1'b0;
      a_start   = 1'b0;
      c_start   = 1'b0;
      mem_we    = 1'b0;
      mem_idx   = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      rd_load   = 1'b0;
      rd_idx    = '0;

      case (state_q)
         IDLE: begin
            c_ready = 1'b1;
            a_ready = !c_valid;
            if (c_valid)      c_start = 1'b1;
            else if (a_valid) a_start = 1'b1;
         end
         A_PUT: begin
            a_ready = 1'b1;
            if (a_valid) begin
               mem_we    = wr_q;
               mem_idx   = base_q + AW'(nb);
               mem_wdata = a_data;
               mem_wmask = a_mask;
               beat_d    = nb;
               if (nb == last_q) begin
                  state_d = D_ACK;
                  beat_d  = '0;
               end
            end
         end
         C_REL: begin
            c_ready = 1'b1;
            if (c_valid) begin
               mem_we    = wr_q;
               mem_idx   = base_q + AW'(nb);
               mem_wdata = c_data;
               mem_wmask = '1;
               beat_d    = nb;
               if (nb == last_q) begin
                  state_d = D_ACK;
                  beat_d  = '0;
               end
            end
         end
         D_DATA: begin
            d_valid = 1'b1;
            if (d_ready) begin
               if (beat_q == last_q) begin
                  state_d = (grant_q || retw_q) ? WAIT_E : IDLE;
                  beat_d  = '0;
                  grant_d = 1'b0;
                  retw_d  = 1'b0;
               end else begin
                  beat_d  = nb;
                  rd_load = 1'b1;
                  rd_idx  = base_q + AW'(nb);
               end
            end
         end
         D_ACK: begin
            d_valid = 1'b1;
            if (d_ready) begin
               state_d = (grant_q || retw_q) ? WAIT_E : IDLE;
               grant_d = 1'b0;
               retw_d  = 1'b0;
            end
         end
         WAIT_E: begin
            e_ready = 1'b1;
            c_ready = 1'b1;
            if (c_valid)      c_start = 1'b1;
            else if (e_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A C beat taken in WAIT_E returns there afterwards, unless E completed in the same cycle.
      if (c_start) begin
         source_d = c_source;
         size_d   = c_size;
         base_d   = c_base;
         beat_d   = '0;
         grant_d  = 1'b0;
         retw_d   = (state_q == WAIT_E) && !e_valid;
         dparam_d = 2'd0;
         dop_d    = 3'd6;
         case (c_opcode)
            3'd7: begin
               mem_we    = 1'b1;
               mem_idx   = c_base;
               mem_wdata = c_data;
               mem_wmask = '1;
               wr_d      = 1'b1;
               last_d    = last_beat(c_size);
               state_d   = (last_beat(c_size) == 3'd0) ? D_ACK : C_REL;
            end
            3'd6: begin
               wr_d    = 1'b0;
               last_d  = '0;
               state_d = D_ACK;
            end
            default: begin
               state_d = retw_d ? WAIT_E : IDLE;
               retw_d  = 1'b0;
            end
         endcase
      end

      if (a_start) begin
         source_d = a_source;
         size_d   = a_size;
         base_d   = a_base;
         beat_d   = '0;
         last_d   = last_beat(a_size);
         grant_d  = 1'b0;
         retw_d   = 1'b0;
         dparam_d = 2'd0;
         case (a_opcode)
            3'd4: begin
               dop_d   = 3'd1;
               state_d = D_DATA;
               rd_load = 1'b1;
               rd_idx  = a_base;
            end
            3'd6: begin
               dop_d    = 3'd5;
               grant_d  = 1'b1;
               dparam_d = (a_param == 3'd0) ? 2'd1 : 2'd0;
               state_d  = D_DATA;
               rd_load  = 1'b1;
               rd_idx   = a_base;
            end
            3'd7: begin
               dop_d    = 3'd4;
               grant_d  = 1'b1;
               dparam_d = (a_param == 3'd0) ? 2'd1 : 2'd0;
               last_d   = '0;
               state_d  = D_ACK;
            end
            default: begin
               // Put opcodes write; the unknown ones run the same beat flow without writing.
               dop_d     = 3'd0;
               wr_d      = (a_opcode == 3'd0) || (a_opcode == 3'd1);
               mem_we    = wr_d;
               mem_idx   = a_base;
               mem_wdata = a_data;
               mem_wmask = a_mask;
               state_d   = (last_beat(a_size) == 3'd0) ? D_ACK : A_PUT;
            end
         endcase
      end

      if (reset) begin
         a_ready = 1'b0;
         c_ready = 1'b0;
         e_ready = 1'b0;
         mem_we  = 1'b0;
      end
   end

endmodule

// File: tb/tb_tl_mem_responder.sv
// Directed bench for tl_mem_responder: put/get merge, GrantData burst with
// D back-pressure, C-over-A priority, address wrap, reset mid-burst, AcquirePerm.
module tb_tl_mem_responder;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        a_valid, a_ready;
   logic [2:0]  a_opcode, a_param, a_size, a_source;
   logic [31:0] a_address;
   logic [7:0]  a_mask;
   logic [63:0] a_data;
   logic        b_valid, b_ready;
   logic        c_valid, c_ready;
   logic [2:0]  c_opcode, c_param, c_size, c_source;
   logic [31:0] c_address;
   logic [63:0] c_data;
   logic        d_valid, d_ready;
   logic [2:0]  d_opcode;
   logic [1:0]  d_param;
   logic [2:0]  d_size, d_source;
   logic [1:0]  d_sink;
   logic [63:0] d_data;
   logic        e_valid, e_ready;
   logic [1:0]  e_sink;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [63:0] pat  [8];
   logic [63:0] rpat [8];
   int lat;

   tl_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(BASE)) dut (
      .clock(clock), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
      .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
      .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready),
      .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
      .c_size(c_size), .c_source(c_source), .c_address(c_address), .c_data(c_data),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
      .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
      .e_valid(e_valid), .e_ready(e_ready), .e_sink(e_sink)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat was accepted.
   task automatic a_beat(input string tag, input logic [2:0] op, input logic [2:0] prm,
                         input logic [2:0] sz, input logic [2:0] src, input logic [31:0] addr,
                         input logic [7:0] mask, input logic [63:0] dat);
      int n = 0;
      a_opcode = op; a_param = prm; a_size = sz; a_source = src;
      a_address = addr; a_mask = mask; a_data = dat; a_valid = 1'b1;
      @(negedge clock);
      while (!a_ready && n < 50) begin @(negedge clock); n++; end
      if (!a_ready) begin
         check({tag, ".a_ready"}, a_ready, 1);
         a_valid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      a_valid = 1'b0;
   endtask

   task automatic c_beat(input string tag, input logic [2:0] op, input logic [2:0] sz,
                         input logic [2:0] src, input logic [31:0] addr, input logic [63:0] dat);
      int n = 0;
      c_opcode = op; c_param = 3'd0; c_size = sz; c_source = src;
      c_address = addr; c_data = dat; c_valid = 1'b1;
      @(negedge clock);
      while (!c_ready && n < 50) begin @(negedge clock); n++; end
      if (!c_ready) begin
         check({tag, ".c_ready"}, c_ready, 1);
         c_valid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      c_valid = 1'b0;
   endtask

   // Waits for one D beat, checks it (again on every stalled cycle), then accepts it.
   task automatic recv_d(input string tag, input logic [2:0] op, input logic [1:0] prm,
                         input logic [2:0] sz, input logic [2:0] src, input logic [63:0] dat,
                         input bit chk, input int stall, output int wait_cyc);
      wait_cyc = 0;
      @(negedge clock);
      while (!d_valid && wait_cyc < 50) begin @(negedge clock); wait_cyc++; end
      check({tag, ".d_valid"}, d_valid, 1);
      if (!d_valid) return;
      for (int s = 0; s <= stall; s++) begin
         if (s > 0) @(negedge clock);
         check({tag, ".opcode"}, d_opcode, op);
         check({tag, ".param"},  d_param,  prm);
         check({tag, ".size"},   d_size,   sz);
         check({tag, ".source"}, d_source, src);
         check({tag, ".sink"},   d_sink,   0);
         if (chk) check({tag, ".data"}, d_data, dat);
      end
      d_ready = 1'b1;
      @(posedge clock); #1;
      d_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         pat[i]  = 64'hC0DE_0000_0000_0000 | 64'(i);
         rpat[i] = 64'hD0D0_0000_0000_0000 | 64'(i);
      end
      reset = 1'b1;
      a_valid = 1'b1; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
      a_address = '0; a_mask = '0; a_data = '0;
      b_ready = 1'b0;
      c_valid = 1'b0; c_opcode = '0; c_param = '0; c_size = '0; c_source = '0;
      c_address = '0; c_data = '0;
      d_ready = 1'b0;
      e_valid = 1'b1; e_sink = '0;

      // Reset state: readies held low even with requests pending
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst.d_valid", d_valid, 0);
      check("rst.a_ready", a_ready, 0);
      check("rst.c_ready", c_ready, 0);
      check("rst.e_ready", e_ready, 0);
      check("rst.b_valid", b_valid, 0);
      @(posedge clock); #1;
      a_valid = 1'b0; e_valid = 1'b0; reset = 1'b0;
      @(negedge clock);
      check("idle.a_ready", a_ready, 1);
      check("idle.c_ready", c_ready, 1);
      check("idle.e_ready", e_ready, 0);
      check("idle.d_valid", d_valid, 0);
      @(posedge clock); #1;

      // Full put, partial put of low 4 bytes, then read back the merged word
      a_beat("put_full", 3'd0, 3'd0, 3'd3, 3'd1, BASE + 32'h10, 8'hFF, 64'hA1A2A3A4_B1B2B3B4);
      recv_d("put_full_ack", 3'd0, 2'd0, 3'd3, 3'd1, '0, 1'b0, 0, lat);
      check("put_lat", lat, 0);
      a_beat("put_part", 3'd1, 3'd0, 3'd3, 3'd1, BASE + 32'h10, 8'h0F, 64'h1122334455667788);
      recv_d("put_part_ack", 3'd0, 2'd0, 3'd3, 3'd1, '0, 1'b0, 0, lat);
      a_beat("get", 3'd4, 3'd0, 3'd3, 3'd4, BASE + 32'h10, 8'h00, '0);
      recv_d("get_data", 3'd1, 2'd0, 3'd3, 3'd4, 64'hA1A2A3A4_55667788, 1'b1, 0, lat);
      check("get_lat", lat, 0);

      // Wrap-around: one past the last word reads word 0
      a_beat("put_w0", 3'd0, 3'd0, 3'd3, 3'd0, BASE, 8'hFF, 64'h0BAD_F00D_1234_5678);
      recv_d("put_w0_ack", 3'd0, 2'd0, 3'd3, 3'd0, '0, 1'b0, 0, lat);
      a_beat("get_wrap", 3'd4, 3'd0, 3'd3, 3'd0, BASE + 32'h2000, 8'h00, '0);
      recv_d("get_wrap_data", 3'd1, 2'd0, 3'd3, 3'd0, 64'h0BAD_F00D_1234_5678, 1'b1, 0, lat);

      // 8-beat put, then AcquireBlock NtoT with d_ready toggling
      for (int i = 0; i < 8; i++)
         a_beat("fill", 3'd0, 3'd0, 3'd6, 3'd3, BASE + 32'h100, 8'hFF, pat[i]);
      recv_d("fill_ack", 3'd0, 2'd0, 3'd6, 3'd3, '0, 1'b0, 0, lat);
      a_beat("acqb", 3'd6, 3'd1, 3'd6, 3'd2, BASE + 32'h100, 8'h00, '0);
      for (int i = 0; i < 8; i++)
         recv_d($sformatf("grant%0d", i), 3'd5, 2'd0, 3'd6, 3'd2, pat[i], 1'b1, i % 2, lat);
      @(negedge clock);
      check("wait_e.d_valid", d_valid, 0);
      check("wait_e.a_ready", a_ready, 0);
      check("wait_e.e_ready", e_ready, 1);
      check("wait_e.c_ready", c_ready, 1);
      repeat (2) @(negedge clock);
      check("wait_e.a_ready_hold", a_ready, 0);
      @(posedge clock); #1;
      e_valid = 1'b1; e_sink = 2'd3;
      @(posedge clock); #1;
      e_valid = 1'b0;
      @(negedge clock);
      check("after_e.a_ready", a_ready, 1);
      check("after_e.e_ready", e_ready, 0);
      @(posedge clock); #1;

      // AcquirePerm NtoB: one dataless Grant toB, Release serviced inside WAIT_E
      a_beat("acqp", 3'd7, 3'd0, 3'd6, 3'd3, BASE + 32'h300, 8'h00, '0);
      recv_d("grant_perm", 3'd4, 2'd1, 3'd6, 3'd3, '0, 1'b0, 0, lat);
      @(negedge clock);
      check("perm.d_valid", d_valid, 0);
      check("perm.a_ready", a_ready, 0);
      check("perm.e_ready", e_ready, 1);
      @(posedge clock); #1;
      c_beat("rel", 3'd6, 3'd6, 3'd6, BASE + 32'h300, '0);
      recv_d("rel_ack", 3'd6, 2'd0, 3'd6, 3'd6, '0, 1'b0, 0, lat);
      @(negedge clock);
      check("perm_back.e_ready", e_ready, 1);
      check("perm_back.a_ready", a_ready, 0);
      @(posedge clock); #1;
      e_valid = 1'b1;
      @(posedge clock); #1;
      e_valid = 1'b0;
      @(negedge clock);
      check("perm_done.a_ready", a_ready, 1);
      @(posedge clock); #1;

      // A and C together: ReleaseData first, then the held Get sees its data
      a_opcode = 3'd4; a_param = '0; a_size = 3'd3; a_source = 3'd5;
      a_address = BASE + 32'h200; a_mask = '0; a_data = '0; a_valid = 1'b1;
      c_opcode = 3'd7; c_param = '0; c_size = 3'd6; c_source = 3'd6;
      c_address = BASE + 32'h200; c_data = rpat[0]; c_valid = 1'b1;
      @(negedge clock);
      check("prio.a_ready", a_ready, 0);
      check("prio.c_ready", c_ready, 1);
      @(posedge clock); #1;
      for (int i = 1; i < 8; i++) begin
         c_data = rpat[i];
         @(negedge clock);
         if (i == 4) check("prio.a_ready_burst", a_ready, 0);
         @(posedge clock); #1;
      end
      c_valid = 1'b0;
      recv_d("prio_rel_ack", 3'd6, 2'd0, 3'd6, 3'd6, '0, 1'b0, 0, lat);
      @(negedge clock);
      check("prio.a_after_c", a_ready, 1);
      @(posedge clock); #1;
      a_valid = 1'b0;
      recv_d("prio_get", 3'd1, 2'd0, 3'd3, 3'd5, rpat[0], 1'b1, 0, lat);

      // Reset during beat 4 of a GrantData burst; memory survives, next Get is clean
      a_beat("acqb2", 3'd6, 3'd2, 3'd6, 3'd1, BASE + 32'h100, 8'h00, '0);
      for (int i = 0; i < 4; i++)
         recv_d($sformatf("grant2_%0d", i), 3'd5, 2'd0, 3'd6, 3'd1, pat[i], 1'b1, 0, lat);
      @(negedge clock);
      check("mid.d_valid", d_valid, 1);
      check("mid.data", d_data, pat[4]);
      reset = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      check("mid_rst.d_valid", d_valid, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("post_rst.a_ready", a_ready, 1);
      check("post_rst.e_ready", e_ready, 0);
      check("post_rst.d_valid", d_valid, 0);
      @(posedge clock); #1;
      a_beat("get_post", 3'd4, 3'd0, 3'd3, 3'd7, BASE + 32'h108, 8'h00, '0);
      recv_d("get_post_data", 3'd1, 2'd0, 3'd3, 3'd7, pat[1], 1'b1, 0, lat);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
